collision_detector: RTL and testbench

- Upstream stage of the ball mover. Scans the VGA raster each frame and flags where the 16x16 ball overlaps walls or paddles, on four ball sides.
- Latches the flags once per frame and drives CollisionX1/X2/Y1/Y2 plus ResetCollision into the ball mover's inputs of the same names.
- Paddle positions come from the paddle controllers. Raster counters come from the VGA sync generator.

---
 rtl/collision_detector.sv | 178 +++++++++++++++++
 tb/tb_collision_detector.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_detector.sv
// Purpose : per-frame ball collision scan; flags wall/paddle overlap on four ball sides for the ball mover.
// Latency : one cycle from a pixel strobe into the shadow flags; outputs update one cycle after the (h=0, v=V_VIS) strobe.
// Backpressure: none; the raster free-runs and the outputs hold between transfers. COLLISION_SIDE_WALLS_EN adds side-column walls.
module collision_detector #(
    parameter int BALL_SIZE = 16,
    parameter int WALL_H    = 8,
    parameter int P1_X      = 32,
    parameter int P2_X      = 600,
    parameter int PAD_W     = 8,
    parameter int PAD_H     = 64,
    parameter int H_VIS     = 640,
    parameter int V_VIS     = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixel_en,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic [1:0] state,
    input  logic [9:0] ballX,
    input  logic [9:0] ballY,
    input  logic [9:0] paddle1Y,
    input  logic [9:0] paddle2Y,
    output logic       CollisionX1,
    output logic       CollisionX2,
    output logic       CollisionY1,
    output logic       CollisionY2,
    output logic       ResetCollision
);

    // Geometry constants, all 11 bits wide so ball/paddle extents never wrap.
    localparam logic [10:0] L_BALL_LAST = 11'(BALL_SIZE - 1);
    localparam logic [10:0] L_PROBE_LO  = 11'(BALL_SIZE / 4);
    localparam logic [10:0] L_PROBE_HI  = 11'(BALL_SIZE - 1 - BALL_SIZE / 4);
    localparam logic [10:0] L_WALL_TOP  = 11'(WALL_H);
    localparam logic [10:0] L_WALL_BOT  = 11'(V_VIS - WALL_H);
    localparam logic [10:0] L_P1_X      = 11'(P1_X);
    localparam logic [10:0] L_P1_XE     = 11'(P1_X + PAD_W);
    localparam logic [10:0] L_P2_X      = 11'(P2_X);
    localparam logic [10:0] L_P2_XE     = 11'(P2_X + PAD_W);
    localparam logic [10:0] L_PAD_H     = 11'(PAD_H);
    localparam logic [10:0] L_H_VIS     = 11'(H_VIS);
    localparam logic [10:0] L_V_VIS     = 11'(V_VIS);
`ifdef COLLISION_SIDE_WALLS_EN
    localparam logic [10:0] L_WALL_LEFT  = 11'(WALL_H);
    localparam logic [10:0] L_WALL_RIGHT = 11'(H_VIS - WALL_H);
`endif

    // Game state encoding shared with the game controller.
    localparam logic [1:0] GS_PLAY = 2'd2;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_SCAN = 2'd1,
        S_HOLD = 2'd2
    } fsm_t;

    fsm_t       fsm_q, fsm_d;
    logic [3:0] shadow_q, shadow_d;   // {left, right, top, bottom}
    logic [3:0] flags_q, flags_d;
    logic       rc_q, rc_d;

    // Zero-extended raster and object coordinates.
    logic [10:0] h_x, v_x, bx, by, p1y, p2y;
    assign h_x = {1'b0, h_cnt};
    assign v_x = {1'b0, v_cnt};
    assign bx  = {1'b0, ballX};
    assign by  = {1'b0, ballY};
    assign p1y = {1'b0, paddle1Y};
    assign p2y = {1'b0, paddle2Y};

    logic visible;
    logic in_hwall, in_pad1, in_pad2, in_swall, obstacle;
    logic row_band, col_band;
    logic probe_l, probe_r, probe_t, probe_b;
    logic [3:0] hit_vec;
    logic frame_origin, frame_end;

    assign visible  = (h_x < L_H_VIS) && (v_x < L_V_VIS);

    // Obstacle map: top/bottom walls, both paddles, optional side walls.
    assign in_hwall = (v_x < L_WALL_TOP) || (v_x >= L_WALL_BOT);
    assign in_pad1  = (h_x >= L_P1_X) && (h_x < L_P1_XE) &&
                      (v_x >= p1y) && (v_x < p1y + L_PAD_H);
    assign in_pad2  = (h_x >= L_P2_X) && (h_x < L_P2_XE) &&
                      (v_x >= p2y) && (v_x < p2y + L_PAD_H);
`ifdef COLLISION_SIDE_WALLS_EN
    assign in_swall = (h_x < L_WALL_LEFT) || ((h_x >= L_WALL_RIGHT) && (h_x < L_H_VIS));
`else
    // Side columns are open so the ball can leave the field and score.
    assign in_swall = 1'b0;
`endif
    assign obstacle = in_hwall || in_pad1 || in_pad2 || in_swall;

    // Side probes sample the middle of each ball edge; corners are excluded
    // so a grazing corner contact does not flip both axes.
    assign row_band = (v_x >= by + L_PROBE_LO) && (v_x <= by + L_PROBE_HI);
    assign col_band = (h_x >= bx + L_PROBE_LO) && (h_x <= bx + L_PROBE_HI);
    assign probe_l  = (h_x == bx) && row_band;
    assign probe_r  = (h_x == bx + L_BALL_LAST) && row_band;
    assign probe_t  = (v_x == by) && col_band;
    assign probe_b  = (v_x == by + L_BALL_LAST) && col_band;

    assign hit_vec  = (pixel_en && visible && obstacle) ?
                      {probe_l, probe_r, probe_t, probe_b} : 4'b0000;

    assign frame_origin = pixel_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign frame_end    = pixel_en && (h_cnt == 10'd0) && (v_x == L_V_VIS);

    // Frame sequencing: wait for a clean frame origin, scan, then hold the report through blanking.
    always_comb begin
        fsm_d    = fsm_q;
        shadow_d = shadow_q;
        flags_d  = flags_q;
        rc_d     = rc_q;
        if (state != GS_PLAY) begin
            fsm_d    = S_WAIT;
            shadow_d = 4'b0000;
            flags_d  = 4'b0000;
            rc_d     = 1'b0;
        end else begin
            case (fsm_q)
                S_WAIT: begin
                    rc_d = 1'b0;
                    if (frame_origin) begin
                        fsm_d    = S_SCAN;
                        shadow_d = hit_vec;
                    end
                end
                S_SCAN: begin
                    if (frame_end) begin
                        flags_d  = shadow_q;
                        shadow_d = 4'b0000;
                        rc_d     = 1'b1;
                        fsm_d    = S_HOLD;
                    end else begin
                        shadow_d = shadow_q | hit_vec;
                    end
                end
                S_HOLD: begin
                    if (frame_origin) begin
                        rc_d     = 1'b0;
                        fsm_d    = S_SCAN;
                        shadow_d = hit_vec;
                    end
                end
                default: begin
                    fsm_d    = S_WAIT;
                    shadow_d = 4'b0000;
                    flags_d  = 4'b0000;
                    rc_d     = 1'b0;
                end
            endcase
        end
    end

    // State, shadow and reported flags with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q    <= S_WAIT;
            shadow_q <= 4'b0000;
            flags_q  <= 4'b0000;
            rc_q     <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            shadow_q <= shadow_d;
            flags_q  <= flags_d;
            rc_q     <= rc_d;
        end
    end

    assign CollisionX1    = flags_q[3];
    assign CollisionX2    = flags_q[2];
    assign CollisionY1    = flags_q[1];
    assign CollisionY2    = flags_q[0];
    assign ResetCollision = rc_q;

endmodule

// File: tb/tb_collision_detector.sv
// Purpose : checks collision_detector against a frame-level model plus literal per-frame expectations.
// Latency : model publishes a frame's flags one cycle after the end-of-frame strobe, like the ball mover expects.
// Backpressure: none; the bench drives a sparse raster around the ball each frame.
module tb_collision_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       pixel_en;
    logic [9:0] h_cnt, v_cnt;
    logic [1:0] state;
    logic [9:0] ballX, ballY, paddle1Y, paddle2Y;
    logic       CollisionX1, CollisionX2, CollisionY1, CollisionY2, ResetCollision;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

    collision_detector dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_en       (pixel_en),
        .h_cnt          (h_cnt),
        .v_cnt          (v_cnt),
        .state          (state),
        .ballX          (ballX),
        .ballY          (ballY),
        .paddle1Y       (paddle1Y),
        .paddle2Y       (paddle2Y),
        .CollisionX1    (CollisionX1),
        .CollisionX2    (CollisionX2),
        .CollisionY1    (CollisionY1),
        .CollisionY2    (CollisionY2),
        .ResetCollision (ResetCollision)
    );

    always #5 clk = ~clk;

    logic [4:0] dut_vec;
    assign dut_vec = {CollisionX1, CollisionX2, CollisionY1, CollisionY2, ResetCollision};

    // Which ball sides touch an obstacle at pixel (h,v); order {left,right,top,bottom}.
    function automatic bit [3:0] side_hits(int h, int v, int bx, int by, int p1, int p2);
        int dx;
        int dy;
        bit blk;
        dx = h - bx;
        dy = v - by;
        if (h >= 640 || v >= 480) return 4'b0000;
        blk = (v < 8) || (v >= 472) ||
              (h >= 32  && h < 40  && v >= p1 && v < p1 + 64) ||
              (h >= 600 && h < 608 && v >= p2 && v < p2 + 64);
`ifdef COLLISION_SIDE_WALLS_EN
        blk = blk || (h < 8) || (h >= 632);
`endif
        if (!blk) return 4'b0000;
        return {dx == 0  && dy >= 4 && dy <= 11,
                dx == 15 && dy >= 4 && dy <= 11,
                dy == 0  && dx >= 4 && dx <= 11,
                dy == 15 && dx >= 4 && dx <= 11};
    endfunction

    // Frame-level model: 0 idle, 1 collecting a frame, 2 showing last frame.
    int       m_mode  = 0;
    bit [3:0] m_acc   = 4'b0;
    bit [3:0] m_shown = 4'b0;
    bit       m_rc    = 1'b0;

    always @(posedge clk) begin : model
        int       mode;
        bit [3:0] acc;
        bit [3:0] shown;
        bit       rc;
        mode  = m_mode;
        acc   = m_acc;
        shown = m_shown;
        rc    = m_rc;
        if (!rst || state != 2'd2) begin
            mode = 0; acc = 4'b0; shown = 4'b0; rc = 1'b0;
        end else if (pixel_en) begin
            if (mode != 1 && h_cnt == 10'd0 && v_cnt == 10'd0) begin
                mode = 1; acc = 4'b0; rc = 1'b0;
            end
            if (mode == 1) begin
                if (h_cnt == 10'd0 && v_cnt == 10'd480) begin
                    shown = acc; acc = 4'b0; rc = 1'b1; mode = 2;
                end else begin
                    acc = acc | side_hits(int'(h_cnt), int'(v_cnt), int'(ballX), int'(ballY),
                                          int'(paddle1Y), int'(paddle2Y));
                end
            end
        end
        m_mode  <= mode;
        m_acc   <= acc;
        m_shown <= shown;
        m_rc    <= rc;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            n_chk++;
            if (dut_vec !== {m_shown, m_rc}) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t dut=%b model=%b", $time, dut_vec, {m_shown, m_rc});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(string nm, logic [4:0] exp);
        n_chk++;
        if (dut_vec !== exp) begin
            n_fail++;
            $display("FAIL %s dut=%b expected=%b", nm, dut_vec, exp);
        end
        n_chk++;
        if ({m_shown, m_rc} !== exp) begin
            n_fail++;
            $display("FAIL %s_model model=%b expected=%b", nm, {m_shown, m_rc}, exp);
        end
    endtask

    task automatic px(int h, int v);
        pixel_en = 1'b1;
        h_cnt    = 10'(h);
        v_cnt    = 10'(v);
        tick();
    endtask

    // Idle cycles park the counters on the end-of-frame point to prove pixel_en gating.
    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            pixel_en = 1'b0;
            h_cnt    = 10'd0;
            v_cnt    = 10'd480;
            tick();
        end
    endtask

    task automatic set_scene(int bx, int by, int p1, int p2);
        ballX    = 10'(bx);
        ballY    = 10'(by);
        paddle1Y = 10'(p1);
        paddle2Y = 10'(p2);
    endtask

    // Pixels in a one-pixel margin around the ball, in raster order, some off-screen.
    task automatic region(int bx, int by);
        for (int v = by - 1; v <= by + 16; v++) begin
            for (int h = bx - 1; h <= bx + 16; h++) begin
                if (h >= 0 && h <= 1023 && v >= 0 && v <= 1023 &&
                    !(h == 0 && (v == 0 || v == 480))) begin
                    px(h, v);
                    if (((h + v) % 5) == 0) idle(1);
                end
            end
        end
    endtask

    task automatic run_frame(string nm, int bx, int by, int p1, int p2, logic [4:0] exp);
        set_scene(bx, by, p1, p2);
        px(0, 0);
        region(bx, by);
        px(0, 480);
        check_lit(nm, exp);
        idle(3);
        px(3, 490);
        px(0, 500);
        idle(2);
    endtask

    initial begin
        rst = 1'b0; state = 2'd0; pixel_en = 1'b0; h_cnt = 10'd0; v_cnt = 10'd0;
        set_scene(304, 224, 208, 208);
        tick();
        cmp_on = 1'b1;
        tick();
        tick();
        check_lit("reset", 5'b00000);
        rst = 1'b1;
        state = 2'd2;

        // Expected vector order: {X1, X2, Y1, Y2, ResetCollision}.
        run_frame("center",      304, 224, 208, 208, 5'b00001);
        run_frame("top_wall",    304,   4, 208, 208, 5'b00101);
        run_frame("bottom_wall", 304, 460, 208, 208, 5'b00011);
        run_frame("side_probes_in_bottom_wall", 304, 466, 208, 208, 5'b11001);
        run_frame("paddle1",      39, 220, 200, 208, 5'b10001);
        run_frame("paddle2",     585, 220, 208, 200, 5'b01001);
        run_frame("paddle1_and_wall", 39,   4,   0, 208, 5'b10101);

        // Leave PLAY mid-scan: everything clears on the next cycle.
        set_scene(304, 4, 208, 208);
        px(0, 0);
        px(308, 4);
        px(309, 4);
        state = 2'd3;
        idle(1);
        check_lit("done_clear", 5'b00000);
        idle(2);

        // Re-enter PLAY at v=100: the partial frame must not be reported.
        state = 2'd2;
        set_scene(304, 460, 208, 208);
        px(0, 100);
        region(304, 460);
        px(0, 480);
        check_lit("midframe_entry", 5'b00000);
        idle(3);
        run_frame("first_full_after_entry", 304, 460, 208, 208, 5'b00011);
        run_frame("clear_after_hits", 304, 224, 208, 208, 5'b00001);
        run_frame("bottom_again", 304, 460, 208, 208, 5'b00011);

        // One-cycle reset at v=300 mid-frame.
        set_scene(304, 460, 208, 208);
        px(0, 0);
        rst = 1'b0;
        px(10, 300);
        rst = 1'b1;
        check_lit("rst_mid", 5'b00000);
        region(304, 460);
        px(0, 480);
        check_lit("rst_no_report", 5'b00000);
        idle(3);
        run_frame("after_rst", 304, 460, 208, 208, 5'b00011);

`ifdef COLLISION_SIDE_WALLS_EN
        run_frame("left_edge",  2, 224, 208, 208, 5'b10111);
        run_frame("offscreen",630, 224, 208, 208, 5'b00111);
`else
        run_frame("left_edge",  2, 224, 208, 208, 5'b00001);
        run_frame("offscreen",630, 224, 208, 208, 5'b00001);
`endif
        run_frame("final_center", 304, 224, 208, 208, 5'b00001);

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
